// File: rtl/acc_cpu_gen.sv
// ---------------------------------------------------------------------------
// acc_cpu_gen : parametrised single-accumulator processor.
//
// Fetches one instruction per FETCH/EXEC pair from an external program
// memory over a req/ack handshake, executes it in one EXEC cycle and stops
// for good on HALT (only reset leaves the HALTED state).
//
// Handshake: imem_req is high for every FETCH cycle and imem_addr (= PC) is
// stable for as long as it stays high. An instruction is transferred on
// every clock edge where imem_req and imem_ack are both 1. imem_ack may be
// raised combinationally in the same cycle as the request.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   imem_req/addr/ack/data  instruction fetch interface
//   pc_dbg, acu_dbg      program counter, accumulator
//   flag_z_dbg, flag_cy_dbg  zero and carry/borrow flags
//   halted               core stopped on HALT
//   retire               one-cycle pulse per executed instruction
//
// Instruction word: {opcode[3:0], ridx[RIDX_W-1:0], imm[DATA_W-1:0]}
// ---------------------------------------------------------------------------
module acc_cpu_gen #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int PC_W   = 5,
    localparam int RIDX_W = $clog2(NREGS),
    localparam int IW     = 4 + RIDX_W + DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [IW-1:0]     imem_data,
    output logic [PC_W-1:0]   pc_dbg,
    output logic [DATA_W-1:0] acu_dbg,
    output logic              flag_z_dbg,
    output logic              flag_cy_dbg,
    output logic              halted,
    output logic              retire
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   acu;
    logic                z;
    logic                cy;
    logic [IW-1:0]       ir;
    logic [DATA_W-1:0]   regs [NREGS];

    // Instruction fields
    logic [3:0]          op;
    logic [RIDX_W-1:0]   ridx;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   rval;

    assign op   = ir[IW-1 -: 4];
    assign ridx = ir[DATA_W +: RIDX_W];
    assign imm  = ir[DATA_W-1:0];
    assign rval = regs[ridx];

    // Next-state values for the EXEC cycle
    logic [DATA_W-1:0]   acu_n;
    logic                z_n;
    logic                cy_n;
    logic                acu_wr;
    logic                reg_wr;
    logic                jump;
    logic                halt_op;
    logic [DATA_W:0]     wide;
    logic [PC_W-1:0]     pc_n;

    always_comb begin
        acu_n   = acu;
        cy_n    = cy;
        acu_wr  = 1'b0;
        reg_wr  = 1'b0;
        jump    = 1'b0;
        halt_op = 1'b0;
        wide    = '0;
        case (op)
            4'd1: begin acu_n = imm;  acu_wr = 1'b1; end
            4'd2: reg_wr = 1'b1;
            4'd3: begin acu_n = rval; acu_wr = 1'b1; end
            4'd4: begin
                wide   = {1'b0, acu} + {1'b0, rval};
                acu_n  = wide[DATA_W-1:0];
                cy_n   = wide[DATA_W];
                acu_wr = 1'b1;
            end
            4'd5: begin
                // Top bit of the widened difference is the borrow (acu < rval).
                wide   = {1'b0, acu} - {1'b0, rval};
                acu_n  = wide[DATA_W-1:0];
                cy_n   = wide[DATA_W];
                acu_wr = 1'b1;
            end
            4'd6: begin
                wide   = {1'b0, acu} + {1'b0, imm};
                acu_n  = wide[DATA_W-1:0];
                cy_n   = wide[DATA_W];
                acu_wr = 1'b1;
            end
            4'd7:  begin acu_n = acu & rval; cy_n = 1'b0; acu_wr = 1'b1; end
            4'd8:  begin acu_n = acu | rval; cy_n = 1'b0; acu_wr = 1'b1; end
            4'd9:  begin acu_n = acu ^ rval; cy_n = 1'b0; acu_wr = 1'b1; end
            4'd10: jump = 1'b1;
            4'd11: jump = z;    // flags tested with their pre-EXEC value
            4'd12: jump = cy;
            4'd15: halt_op = 1'b1;
            default: ;          // NOP, and 13/14 behave as NOP
        endcase
        z_n  = acu_wr ? (acu_n == '0) : z;
        pc_n = jump ? imm[PC_W-1:0] : pc + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= S_FETCH;
            pc     <= '0;
            acu    <= '0;
            z      <= 1'b0;
            cy     <= 1'b0;
            ir     <= '0;
            halted <= 1'b0;
            retire <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_data;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    retire <= 1'b1;
                    pc     <= pc_n;
                    acu    <= acu_n;
                    z      <= z_n;
                    cy     <= cy_n;
                    if (reg_wr) begin
                        regs[ridx] <= acu;
                    end
                    if (halt_op) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end else begin
                        state  <= S_FETCH;
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Request is combinational on state so it drops immediately under reset.
    assign imem_req    = rstn && (state == S_FETCH);
    assign imem_addr   = pc;
    assign pc_dbg      = pc;
    assign acu_dbg     = acu;
    assign flag_z_dbg  = z;
    assign flag_cy_dbg = cy;

endmodule

// File: tb/tb_acc_cpu_gen.sv
// ---------------------------------------------------------------------------
// tb_acc_cpu_gen : self-checking bench for acc_cpu_gen (default parameters).
// A program memory array answers fetches; an instruction-level model of the
// architecture is stepped on each retire pulse and compared to the debug
// outputs.
// ---------------------------------------------------------------------------
module tb_acc_cpu_gen;

    localparam int DATA_W = 8;
    localparam int NREGS  = 4;
    localparam int PC_W   = 5;
    localparam int IW     = 4 + 2 + DATA_W;
    localparam int DMOD   = 1 << DATA_W;
    localparam int PSIZE  = 1 << PC_W;
    localparam int VW     = PC_W + DATA_W + 3;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [IW-1:0]     imem_data;
    logic [PC_W-1:0]   pc_dbg;
    logic [DATA_W-1:0] acu_dbg;
    logic              flag_z_dbg;
    logic              flag_cy_dbg;
    logic              halted;
    logic              retire;

    acc_cpu_gen dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .pc_dbg      (pc_dbg),
        .acu_dbg     (acu_dbg),
        .flag_z_dbg  (flag_z_dbg),
        .flag_cy_dbg (flag_cy_dbg),
        .halted      (halted),
        .retire      (retire)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- program memory ----------------
    logic [IW-1:0] mem [PSIZE];
    int            ack_mode = 0;   // 0: always ack, 1: never, 2: random
    logic          rnd_ack = 1'b1;

    always @(negedge clk) rnd_ack = ($urandom_range(0, 2) != 0);

    assign imem_data = mem[imem_addr];
    assign imem_ack  = (ack_mode == 0) || ((ack_mode == 2) && rnd_ack);

    // ---------------- reference model ----------------
    int m_pc, m_acu, m_z, m_c, m_halt;
    int m_r [NREGS];
    int n_cmp = 0;
    int n_fail = 0;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {pc_dbg, acu_dbg, flag_z_dbg, flag_cy_dbg, halted};

    function automatic logic [VW-1:0] model_vec();
        logic [PC_W-1:0]   p;
        logic [DATA_W-1:0] a;
        p = PC_W'(m_pc);
        a = DATA_W'(m_acu);
        return {p, a, m_z[0], m_c[0], m_halt[0]};
    endfunction

    function automatic logic [IW-1:0] enc(input int op, input int ri, input int imm);
        logic [3:0]        o;
        logic [1:0]        r;
        logic [DATA_W-1:0] i;
        o = 4'(op);
        r = 2'(ri);
        i = DATA_W'(imm);
        return {o, r, i};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_acu = 0; m_z = 0; m_c = 0; m_halt = 0;
        for (int i = 0; i < NREGS; i++) m_r[i] = 0;
    endtask

    // Executes the instruction at the model PC with plain integer arithmetic.
    task automatic model_step();
        logic [IW-1:0] w;
        int op, ri, imm, rv, nxt, s;
        w   = mem[m_pc];
        op  = int'(w[IW-1 -: 4]);
        ri  = int'(w[DATA_W +: 2]);
        imm = int'(w[DATA_W-1:0]);
        rv  = m_r[ri];
        nxt = (m_pc + 1) % PSIZE;
        case (op)
            1: begin m_acu = imm; m_z = (m_acu == 0); end
            2: m_r[ri] = m_acu;
            3: begin m_acu = rv; m_z = (m_acu == 0); end
            4, 6: begin
                s = m_acu + ((op == 4) ? rv : imm);
                m_c = (s >= DMOD); m_acu = s % DMOD; m_z = (m_acu == 0);
            end
            5: begin
                m_c = (m_acu < rv); m_acu = (m_acu - rv + DMOD) % DMOD; m_z = (m_acu == 0);
            end
            7: begin m_acu = m_acu & rv; m_c = 0; m_z = (m_acu == 0); end
            8: begin m_acu = m_acu | rv; m_c = 0; m_z = (m_acu == 0); end
            9: begin m_acu = m_acu ^ rv; m_c = 0; m_z = (m_acu == 0); end
            10: nxt = imm % PSIZE;
            11: if (m_z != 0) nxt = imm % PSIZE;
            12: if (m_c != 0) nxt = imm % PSIZE;
            15: m_halt = 1;
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < PSIZE; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Waits (bounded) for n retire pulses, stepping the model on each one.
    task automatic run_retires(input int n, input int budget, output int got, output int cycles);
        got = 0;
        cycles = 0;
        while (got < n && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (retire === 1'b1) begin
                model_step();
                got++;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_mem();
        ack_mode = 0;
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_vec !== '0 || imem_req !== 1'b0 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got vec=%h req=%b retire=%b, want vec=0 req=0 retire=0",
                     dut_vec, imem_req, retire);
        end
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got req=%b addr=%0d, want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_defaults();
        int got, cyc;
        clear_mem();
        mem[0] = enc(1, 0, 2);  mem[1] = enc(2, 0, 0);  mem[2] = enc(1, 0, 7);
        mem[3] = enc(5, 0, 0);  mem[4] = enc(2, 1, 0);  mem[5] = enc(3, 0, 0);
        mem[6] = enc(3, 1, 0);  mem[7] = enc(15, 0, 0);
        ack_mode = 0;
        do_reset();
        run_retires(5, 40, got, cyc);
        n_cmp++;
        if (got != 5 || cyc != 10) begin
            n_fail++;
            $display("FAIL defaults_timing: got %0d retires in %0d cycles, want 5 in 10", got, cyc);
        end
        n_cmp++;
        if (dut_vec !== model_vec() || acu_dbg !== 8'd5 || flag_z_dbg !== 1'b0 || flag_cy_dbg !== 1'b0) begin
            n_fail++;
            $display("FAIL defaults_state: got %h, want %h (acu=5 z=0 c=0)", dut_vec, model_vec());
        end
        run_retires(1, 10, got, cyc);
        n_cmp++;
        if (got != 1 || acu_dbg !== 8'd2) begin
            n_fail++;
            $display("FAIL defaults_r0: got acu=%0d, want 2", acu_dbg);
        end
        run_retires(2, 20, got, cyc);
        n_cmp++;
        if (got != 2 || dut_vec !== model_vec() || acu_dbg !== 8'd5 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL defaults_r1_halt: got %h, want %h (acu=5 halted)", dut_vec, model_vec());
        end
    endtask

    task automatic test_borrow_zero();
        int got, cyc;
        clear_mem();
        mem[0] = enc(1, 0, 2);  mem[1] = enc(2, 1, 0);  mem[2] = enc(1, 0, 3);
        mem[3] = enc(5, 1, 0);  mem[4] = enc(5, 1, 0);  mem[5] = enc(6, 0, 1);
        mem[6] = enc(15, 0, 0);
        ack_mode = 0;
        do_reset();
        run_retires(4, 40, got, cyc);
        n_cmp++;
        if (got != 4 || {acu_dbg, flag_cy_dbg, flag_z_dbg} !== {8'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_no_borrow: got acu=%h c=%b z=%b, want 01 0 0", acu_dbg, flag_cy_dbg, flag_z_dbg);
        end
        run_retires(1, 10, got, cyc);
        n_cmp++;
        if (got != 1 || {acu_dbg, flag_cy_dbg, flag_z_dbg} !== {8'hFF, 1'b1, 1'b0} || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL sub_borrow: got acu=%h c=%b z=%b, want ff 1 0", acu_dbg, flag_cy_dbg, flag_z_dbg);
        end
        run_retires(1, 10, got, cyc);
        n_cmp++;
        if (got != 1 || {acu_dbg, flag_cy_dbg, flag_z_dbg} !== {8'h00, 1'b1, 1'b1} || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL addi_wrap: got acu=%h c=%b z=%b, want 00 1 1", acu_dbg, flag_cy_dbg, flag_z_dbg);
        end
    endtask

    task automatic test_branch();
        int got, cyc;
        clear_mem();
        mem[0]  = enc(1, 0, 0);     mem[1]  = enc(11, 0, 9);
        mem[9]  = enc(1, 0, 1);     mem[10] = enc(11, 0, 0);
        mem[11] = enc(1, 0, 8'hFF); mem[12] = enc(12, 0, 20);
        mem[13] = enc(6, 0, 1);     mem[14] = enc(12, 0, 20);
        mem[20] = enc(15, 0, 0);
        ack_mode = 0;
        do_reset();
        run_retires(2, 20, got, cyc);
        n_cmp++;
        if (got != 2 || pc_dbg !== 5'd9) begin
            n_fail++;
            $display("FAIL jz_taken: got pc=%0d, want 9", pc_dbg);
        end
        run_retires(2, 20, got, cyc);
        n_cmp++;
        if (got != 2 || pc_dbg !== 5'd11) begin
            n_fail++;
            $display("FAIL jz_not_taken: got pc=%0d, want 11", pc_dbg);
        end
        run_retires(2, 20, got, cyc);
        n_cmp++;
        if (got != 2 || pc_dbg !== 5'd13) begin
            n_fail++;
            $display("FAIL jc_not_taken: got pc=%0d, want 13", pc_dbg);
        end
        run_retires(2, 20, got, cyc);
        n_cmp++;
        if (got != 2 || pc_dbg !== 5'd20 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL jc_taken: got pc=%0d vec=%h, want pc=20 vec=%h", pc_dbg, dut_vec, model_vec());
        end
    endtask

    task automatic test_stall();
        clear_mem();
        ack_mode = 1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 5'd0 || retire !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got req=%b addr=%0d retire=%b, want 1 0 0",
                         i, imem_req, imem_addr, retire);
            end
        end
        ack_mode = 0;
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b0 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_exec: got req=%b retire=%b, want 0 0", imem_req, retire);
        end
        @(negedge clk);
        n_cmp++;
        if (retire !== 1'b1 || pc_dbg !== 5'd1 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_retire: got retire=%b pc=%0d req=%b, want 1 1 1", retire, pc_dbg, imem_req);
        end
    endtask

    task automatic test_wrap_halt();
        int got, cyc;
        clear_mem();
        mem[0] = enc(12, 0, 5);  mem[1] = enc(1, 0, 8'hFF); mem[2] = enc(6, 0, 1);
        mem[3] = enc(10, 0, 31); mem[31] = enc(0, 0, 0);    mem[5] = enc(15, 0, 0);
        ack_mode = 0;
        do_reset();
        run_retires(5, 40, got, cyc);
        n_cmp++;
        if (got != 5 || pc_dbg !== 5'd0 || imem_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL pc_wrap: got pc=%0d addr=%0d, want 0 0", pc_dbg, imem_addr);
        end
        run_retires(2, 20, got, cyc);
        n_cmp++;
        if (got != 2 || halted !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL halt_enter: got vec=%h, want %h", dut_vec, model_vec());
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (imem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_hold: cycle %0d got req=%b retire=%b halted=%b, want 0 0 1",
                         i, imem_req, retire, halted);
            end
        end
    endtask

    task automatic test_reset_mid();
        int got, cyc;
        clear_mem();
        mem[0] = enc(3, 0, 0); mem[1] = enc(6, 0, 5); mem[2] = enc(2, 0, 0);
        mem[3] = enc(6, 0, 1); mem[4] = enc(15, 0, 0);
        ack_mode = 0;
        do_reset();
        run_retires(3, 30, got, cyc);
        ack_mode = 1;
        @(negedge clk);
        ack_mode = 0;
        rstn = 1'b0;                     // ack pending in FETCH at this edge
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (got != 3 || dut_vec !== '0 || retire !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: got vec=%h retire=%b req=%b, want 0 0 0", dut_vec, retire, imem_req);
        end
        rstn = 1'b1;
        run_retires(1, 10, got, cyc);    // LDR R0 must see the cleared register
        n_cmp++;
        if (got != 1 || acu_dbg !== 8'd0 || flag_z_dbg !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_regs_clear: got acu=%h z=%b, want 00 1", acu_dbg, flag_z_dbg);
        end
        run_retires(4, 30, got, cyc);
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (got != 4 || dut_vec !== '0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_from_halt: got vec=%h req=%b, want 0 0", dut_vec, imem_req);
        end
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_resume: got req=%b addr=%0d, want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        int got, cyc;
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < PSIZE; i++) begin
                mem[i] = enc($urandom_range(0, 14), $urandom_range(0, NREGS - 1), $urandom_range(0, DMOD - 1));
            end
            ack_mode = 2;
            do_reset();
            for (int k = 0; k < 60; k++) begin
                run_retires(1, 30, got, cyc);
                n_cmp++;
                if (got != 1 || dut_vec !== model_vec()) begin
                    n_fail++;
                    $display("FAIL random_r%0d_i%0d: got vec=%h retired=%0d, want vec=%h retired=1",
                             round, k, dut_vec, got, model_vec());
                    break;
                end
            end
        end
        ack_mode = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_borrow_zero();
        test_branch();
        test_stall();
        test_wrap_halt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
